// File: rtl/router_pkg.sv
// -----------------------------------------------------------------------------
// router_pkg
// Shared definitions for the router datapath (1x4 routing stage and the 4x1
// egress merger).
//   PORT_IDX_W / FIFO_PTR_W : index and pointer widths for the default sizes
//   state_t                 : merge arbiter states
//   beat_t                  : one stored beat {last, data}
// -----------------------------------------------------------------------------
package router_pkg;

  localparam int NUM_PORTS_DEF  = 4;
  localparam int DATA_WIDTH_DEF = 32;
  localparam int FIFO_DEPTH_DEF = 4;

  localparam int PORT_IDX_W = $clog2(NUM_PORTS_DEF);
  // The extra MSB distinguishes full from empty when the address bits match.
  localparam int FIFO_PTR_W = $clog2(FIFO_DEPTH_DEF) + 1;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  typedef struct packed {
    logic                      last;
    logic [DATA_WIDTH_DEF-1:0] data;
  } beat_t;

endpackage

// File: rtl/router_sync_fifo.sv
// -----------------------------------------------------------------------------
// router_sync_fifo
// Single-clock FIFO holding one ingress port's beats.
//   clk, reset : clock, asynchronous active-high reset (pointers only)
//   push, din  : write request and beat; ignored while full
//   pop        : read request; ignored while empty
//   full/empty : occupancy flags
//   head       : oldest stored beat (valid when !empty)
// -----------------------------------------------------------------------------
module router_sync_fifo
  import router_pkg::*;
#(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;

  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [WIDTH-1:0] mem_r [DEPTH];
  logic             do_push_s;
  logic             do_pop_s;

  assign empty     = (wr_ptr_r == rd_ptr_r);
  assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                     (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign do_push_s = push & ~full;
  assign do_pop_s  = pop & ~empty;
  assign head      = mem_r[rd_ptr_r[AW-1:0]];

  // Pointer update; reset empties the FIFO regardless of stored contents.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
    end
  end

  // Beat storage; contents are meaningless until written, so no reset.
  always_ff @(posedge clk) begin
    if (do_push_s) mem_r[wr_ptr_r[AW-1:0]] <= din;
  end

endmodule

// File: rtl/router_merge_4x1.sv
// -----------------------------------------------------------------------------
// router_merge_4x1
// Merges packets from NUM_PORTS ingress ports onto one output stream. Each port
// has a small FIFO; a packet-locked round-robin arbiter picks one port and a
// registered output stage drives a valid/ready interface. Packets are never
// interleaved.
//   clk, reset             : clock, asynchronous active-high reset
//   in_data/valid/last     : per-port beat, port i at [i*DATA_WIDTH +: DATA_WIDTH]
//   in_ready               : per-port FIFO not full (0 while in reset)
//   out_data/last/src      : merged beat, end-of-packet, source port
//   out_valid / out_ready  : output handshake
// -----------------------------------------------------------------------------
module router_merge_4x1
  import router_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int NUM_PORTS  = NUM_PORTS_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_PORTS-1:0]            in_valid,
  input  logic [NUM_PORTS-1:0]            in_last,
  output logic [NUM_PORTS-1:0]            in_ready,
  output logic [DATA_WIDTH-1:0]           out_data,
  output logic                            out_valid,
  output logic                            out_last,
  output logic [$clog2(NUM_PORTS)-1:0]    out_src,
  input  logic                            out_ready
);

  localparam int IDX_W  = $clog2(NUM_PORTS);
  localparam int BEAT_W = DATA_WIDTH + 1;

  logic [NUM_PORTS-1:0] full_s;
  logic [NUM_PORTS-1:0] empty_s;
  logic [NUM_PORTS-1:0] push_s;
  logic [NUM_PORTS-1:0] pop_s;
  logic [BEAT_W-1:0]    head_s [NUM_PORTS];

  state_t               state_r;
  logic [IDX_W-1:0]     grant_r;
  logic [IDX_W-1:0]     last_grant_r;

  logic                 slot_free_s;
  logic                 pick_found_s;
  logic [IDX_W-1:0]     pick_idx_s;
  logic [IDX_W-1:0]     cand_s;
  logic                 pop_en_s;
  logic [IDX_W-1:0]     pop_idx_s;
  logic [BEAT_W-1:0]    sel_beat_s;

  // Gating with reset keeps in_ready low for the whole reset interval.
  assign in_ready    = ~full_s & {NUM_PORTS{~reset}};
  assign push_s      = in_valid & in_ready;
  assign slot_free_s = ~out_valid | out_ready;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_fifo
    router_sync_fifo #(
      .WIDTH (BEAT_W),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push_s[i]),
      .pop   (pop_s[i]),
      .din   ({in_last[i], in_data[i*DATA_WIDTH +: DATA_WIDTH]}),
      .full  (full_s[i]),
      .empty (empty_s[i]),
      .head  (head_s[i])
    );
  end

  // Round-robin search: first non-empty port after last_grant, wrapping; the
  // offset NUM_PORTS wraps back onto last_grant itself, giving it lowest rank.
  always_comb begin
    pick_found_s = 1'b0;
    pick_idx_s   = '0;
    cand_s       = '0;
    for (int off = 1; off <= NUM_PORTS; off++) begin
      cand_s = last_grant_r + IDX_W'(off);
      if (!pick_found_s && !empty_s[cand_s]) begin
        pick_found_s = 1'b1;
        pick_idx_s   = cand_s;
      end else begin
        pick_found_s = pick_found_s;
      end
    end
  end

  // Pop decision: a new grant in IDLE, only the locked port in BUSY.
  always_comb begin
    pop_en_s  = 1'b0;
    pop_idx_s = grant_r;
    case (state_r)
      ST_IDLE: begin
        if (slot_free_s && pick_found_s) begin
          pop_en_s  = 1'b1;
          pop_idx_s = pick_idx_s;
        end else begin
          pop_en_s  = 1'b0;
        end
      end
      ST_BUSY: begin
        if (slot_free_s && !empty_s[grant_r]) begin
          pop_en_s = 1'b1;
        end else begin
          pop_en_s = 1'b0;
        end
      end
      default: pop_en_s = 1'b0;
    endcase
  end

  // One-hot pop strobe and head mux for the selected port.
  always_comb begin
    pop_s            = '0;
    pop_s[pop_idx_s] = pop_en_s;
    sel_beat_s       = head_s[pop_idx_s];
  end

  // Arbiter FSM and output register; the held beat stays put while stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      grant_r      <= '0;
      last_grant_r <= IDX_W'(NUM_PORTS - 1);
      out_valid    <= 1'b0;
      out_last     <= 1'b0;
      out_data     <= '0;
      out_src      <= '0;
    end else if (pop_en_s) begin
      out_valid    <= 1'b1;
      out_data     <= sel_beat_s[DATA_WIDTH-1:0];
      out_last     <= sel_beat_s[DATA_WIDTH];
      out_src      <= pop_idx_s;
      grant_r      <= pop_idx_s;
      last_grant_r <= pop_idx_s;
      state_r      <= sel_beat_s[DATA_WIDTH] ? ST_IDLE : ST_BUSY;
    end else if (out_ready) begin
      // Held beat accepted with nothing to replace it: bubble.
      out_valid    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_router_merge_4x1.sv
// Scoreboard bench for router_merge_4x1: accepted ingress beats are queued per
// port; a negedge monitor pops and compares each beat the output delivers.
module tb_router_merge_4x1;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [127:0] in_data = '0;
  logic [3:0]   in_valid = '0;
  logic [3:0]   in_last = '0;
  logic [3:0]   in_ready;
  logic [31:0]  out_data;
  logic         out_valid;
  logic         out_last;
  logic [1:0]   out_src;
  logic         out_ready = 1'b1;

  router_merge_4x1 dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_src   (out_src),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    int          src;
    logic        last;
    logic [31:0] data;
  } obs_t;

  logic [32:0] exp_q [4][$];
  obs_t        obs_q [$];
  int          chk_cnt = 0;
  int          pass_cnt = 0;
  int          cyc = 0;
  logic [3:0]  acc;
  int          rem [4];

  logic        in_pkt = 1'b0;
  logic [1:0]  pkt_src = 2'd0;
  logic        hold_v = 1'b0;
  logic        hold_last;
  logic [1:0]  hold_src;
  logic [31:0] hold_data;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic int sb_size();
    int s = 0;
    for (int p = 0; p < 4; p++) s += exp_q[p].size();
    return s;
  endfunction

  task automatic drive_beat(input int p, input logic [31:0] d, input logic l);
    in_valid[p] = 1'b1;
    in_data[p*32 +: 32] = d;
    in_last[p] = l;
  endtask

  // Record beats the DUT will accept at the coming edge, then advance a cycle.
  task automatic step();
    @(negedge clk);
    for (int p = 0; p < 4; p++) begin
      acc[p] = in_valid[p] && in_ready[p] && !reset;
      if (acc[p]) exp_q[p].push_back({in_last[p], in_data[p*32 +: 32]});
    end
    @(posedge clk);
    #1;
    for (int p = 0; p < 4; p++) if (acc[p]) in_valid[p] = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    out_ready = 1'b1;
    while (!(sb_size() == 0 && !out_valid && in_valid == 4'd0) && n < 200) begin
      step();
      n++;
    end
    check({name, "_drain_done"}, (n < 200), 1);
  endtask

  task automatic clear_sb();
    for (int p = 0; p < 4; p++) begin
      exp_q[p].delete();
      rem[p] = 0;
    end
    obs_q.delete();
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    in_valid = '0;
    out_ready = 1'b1;
    clear_sb();
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 4'h0);
    check("rst_out", {out_valid, out_last, out_src, out_data}, 36'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("rst_release_in_ready", in_ready, 4'hF);
  endtask

  // Monitor: every delivered beat must be the next queued beat of its port,
  // packets must not interleave, and stalled beats must hold still.
  always @(negedge clk) begin
    if (reset) begin
      in_pkt = 1'b0;
      hold_v = 1'b0;
    end else begin
      if (hold_v)
        check("hold_stable", {out_valid, out_last, out_src, out_data},
              {1'b1, hold_last, hold_src, hold_data});
      if (out_valid && out_ready) begin
        if (in_pkt) check("no_interleave", out_src, pkt_src);
        check("beat_expected", (exp_q[out_src].size() > 0), 1);
        if (exp_q[out_src].size() > 0)
          check($sformatf("beat_port%0d", out_src), {out_last, out_data},
                exp_q[out_src].pop_front());
        obs_q.push_back('{cyc, int'(out_src), out_last, out_data});
        in_pkt  = !out_last;
        pkt_src = out_src;
      end
      hold_v    = out_valid && !out_ready;
      hold_last = out_last;
      hold_src  = out_src;
      hold_data = out_data;
    end
  end

  task automatic check_order(input string name, input int srcs [4]);
    check({name, "_count"}, obs_q.size(), 4);
    if (obs_q.size() >= 4)
      for (int k = 0; k < 4; k++) begin
        check($sformatf("%s_src%0d", name, k), obs_q[k].src, srcs[k]);
        check($sformatf("%s_data%0d", name, k), obs_q[k].data, 32'h10 + srcs[k]);
        if (k > 0) check($sformatf("%s_gap%0d", name, k), obs_q[k].cyc - obs_q[k-1].cyc, 1);
      end
  endtask

  initial begin
    int sent;
    int n;
    apply_reset();

    // Single beat: visible one edge after acceptance.
    drive_beat(2, 32'hA5A5_0002, 1'b1);
    step();
    check("t1_not_yet", out_valid, 1'b0);
    @(posedge clk);
    #1;
    check("t1_beat", {out_valid, out_last, out_src, out_data}, {1'b1, 1'b1, 2'd2, 32'hA5A5_0002});
    drain("t1");

    // Round robin from reset, then from last_grant=1.
    apply_reset();
    for (int p = 0; p < 4; p++) drive_beat(p, 32'h10 + p, 1'b1);
    step();
    drain("t2a");
    check_order("t2a", '{0, 1, 2, 3});
    drive_beat(1, 32'h21, 1'b1);
    step();
    drain("t2x");
    obs_q.delete();
    for (int p = 0; p < 4; p++) drive_beat(p, 32'h10 + p, 1'b1);
    step();
    drain("t2b");
    check_order("t2b", '{2, 3, 0, 1});

    // No interleave: port 1 packet with a gap, port 0 waits.
    obs_q.delete();
    drive_beat(1, 32'h1000_0001, 1'b0);
    step();
    drive_beat(1, 32'h1000_0002, 1'b0);
    drive_beat(0, 32'h0000_00F0, 1'b1);
    step();
    step();
    step();
    drive_beat(1, 32'h1000_0003, 1'b1);
    step();
    drain("t3");
    check("t3_count", obs_q.size(), 4);
    if (obs_q.size() >= 4) begin
      check("t3_src", {obs_q[0].src[1:0], obs_q[1].src[1:0], obs_q[2].src[1:0], obs_q[3].src[1:0]},
            {2'd1, 2'd1, 2'd1, 2'd0});
      check("t3_bubbles", obs_q[2].cyc - obs_q[1].cyc, 3);
      check("t3_port0_after", obs_q[3].cyc - obs_q[2].cyc, 1);
    end

    // Backpressure: output reg + FIFO_DEPTH beats then in_ready[3] drops.
    obs_q.delete();
    out_ready = 1'b0;
    sent = 0;
    n = 0;
    for (int k = 0; k < 7; k++) begin
      if (!in_valid[3]) begin
        drive_beat(3, 32'h3000_0000 + sent, (sent == 7));
        sent++;
      end
      step();
      if (acc[3]) n++;
    end
    check("t4_accepted", n, 5);
    check("t4_full_ready", in_ready[3], 1'b0);
    check("t4_held_beat", {out_valid, out_data}, {1'b1, 32'h3000_0000});
    out_ready = 1'b1;
    while ((sent < 8 || in_valid[3]) && n < 100) begin
      if (!in_valid[3] && sent < 8) begin
        drive_beat(3, 32'h3000_0000 + sent, (sent == 7));
        sent++;
      end
      step();
      n++;
    end
    drain("t4");
    check("t4_count", obs_q.size(), 8);
    for (int k = 0; k < 8 && k < obs_q.size(); k++)
      check($sformatf("t4_order%0d", k), {obs_q[k].last, obs_q[k].data},
            {(k == 7), 32'h3000_0000 + k});

    // Reset during beat 2 of a 4-beat packet.
    apply_reset();
    sent = 0;
    n = 0;
    while (n < 20 && !(out_valid && out_data == 32'h6000_0001)) begin
      if (!in_valid[3] && sent < 4) begin
        drive_beat(3, 32'h6000_0000 + sent, (sent == 3));
        sent++;
      end
      step();
      n++;
    end
    check("t6_reached_beat2", out_data, 32'h6000_0001);
    reset = 1'b1;
    in_valid = '0;
    #1;
    check("t6_async_valid", out_valid, 1'b0);
    check("t6_rst_ready", in_ready, 4'h0);
    clear_sb();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("t6_release_ready", in_ready, 4'hF);
    drive_beat(3, 32'h6300_00AA, 1'b1);
    step();
    drain("t6");
    check("t6_count", obs_q.size(), 1);
    if (obs_q.size() >= 1)
      check("t6_beat", {obs_q[0].src[1:0], obs_q[0].data}, {2'd3, 32'h6300_00AA});

    // Randomised traffic with random backpressure.
    apply_reset();
    repeat (1500) begin
      for (int p = 0; p < 4; p++)
        if (!in_valid[p] && $urandom_range(0, 9) < 6) begin
          if (rem[p] == 0) rem[p] = $urandom_range(1, 4);
          drive_beat(p, $urandom, (rem[p] == 1));
          rem[p]--;
        end
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    out_ready = 1'b1;
    n = 0;
    while ((rem[0] + rem[1] + rem[2] + rem[3] > 0 || in_valid != 4'd0) && n < 100) begin
      for (int p = 0; p < 4; p++)
        if (!in_valid[p] && rem[p] > 0) begin
          drive_beat(p, $urandom, (rem[p] == 1));
          rem[p]--;
        end
      step();
      n++;
    end
    drain("rnd");
    check("rnd_sb_empty", sb_size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/router_merge_4x1.md
Name: router_merge_4x1

Overview:
Egress-side merger, the inverse of the 1x4 routing stage: it collects packets from NUM_PORTS input ports onto a single output stream.
- Each input port has a small ingress FIFO.
- A packet-locked round-robin arbiter selects one port at a time, and a registered output stage drives a valid/ready interface.
- Packets are never interleaved on the output.

Parameters:
DATA_WIDTH, 32, width of one data beat
NUM_PORTS, 4, number of input ports (power of two, >=2)
FIFO_DEPTH, 4, entries per ingress FIFO (power of two, >=2)

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  asynchronous, active-high reset
in_data  input  NUM_PORTS*DATA_WIDTH  port i beat at [i*DATA_WIDTH +: DATA_WIDTH]
in_valid  input  NUM_PORTS  per-port beat valid
in_last  input  NUM_PORTS  per-port end-of-packet marker
in_ready  output  NUM_PORTS  per-port ingress FIFO not full
out_data  output  DATA_WIDTH  merged beat
out_valid  output  1  output beat valid
out_last  output  1  end-of-packet for out_data
out_src  output  $clog2(NUM_PORTS)  source port of current beat
out_ready  input  1  downstream accepts beat

Behaviour:
- Reset is asynchronous and active-high; clock is clk.
- Reset values: in_ready all 0 while reset is asserted, all 1 on the first cycle after release. out_valid=0, out_last=0, out_data=0, out_src=0. FIFOs empty, FSM=IDLE, last_grant=NUM_PORTS-1, so port 0 has first priority.
- Ingress:
  - in_ready[i] = !full[i].
  - Push when in_valid[i] && in_ready[i]; {last, data} are stored together.
  - No push when full; push and pop in the same cycle is legal when the FIFO is non-empty.
- Output register:
  - "slot free" = !out_valid || out_ready.
  - Data, last and src are held stable while out_valid && !out_ready.
- FSM IDLE:
  - If any FIFO is non-empty and the slot is free, grant the first non-empty port searching from last_grant+1, wrapping modulo NUM_PORTS.
  - In the same cycle, pop its head into the output register and set last_grant to that port.
  - If the popped beat has last=1, stay IDLE (single-beat packet). Otherwise go to BUSY with grant locked.
- FSM BUSY:
  - Each cycle where the granted FIFO is non-empty and the slot is free, pop one beat into the output register.
  - A beat with last=1 returns the FSM to IDLE.
  - If the granted FIFO is empty, insert a bubble (out_valid drops once the held beat is accepted) and keep the grant. Other ports wait regardless of their occupancy.
- Latency: for an idle block with a free slot, a beat accepted at edge N is on out_data with out_valid=1 after edge N+1. Sustained throughput is 1 beat/cycle with out_ready held high.
- Fairness: after a packet from port k, every other non-empty port is served once before k again.
- Simultaneous events:
  - Pushing into the granted FIFO while popping it is allowed.
  - Arrival on a lower-numbered port does not pre-empt a locked grant.
- Reset mid-packet: all FIFO contents and partial packets are discarded, and the output drops valid immediately. No recovery framing is emitted.
- Width rules:
  - FIFO pointers are $clog2(FIFO_DEPTH)+1 bits; the extra MSB is used for the full/empty distinction.
  - Round-robin index arithmetic is modulo NUM_PORTS.

Decomposition:
- Shared package router_pkg:
  - Constants PORT_IDX_W = $clog2(NUM_PORTS) and FIFO_PTR_W.
  - FSM state enum {ST_IDLE, ST_BUSY}.
  - A beat struct {last, data} reused by the 1x4 routing stage.
- Sub-module router_sync_fifo: synchronous FIFO with push/pop/full/empty/head, generated NUM_PORTS times.
- Arbiter and output register live in the top module.

Test Plan:
1. Single beat: port 2 sends data=0xA5A5_0002, last=1 -> after 1 edge out_valid=1, out_data=0xA5A5_0002, out_src=2, out_last=1; FSM stays IDLE.
2. Round robin: all 4 ports push one single-beat packet (data=0x10+i) in the same cycle after reset -> output order src 0,1,2,3 on 4 consecutive cycles. Repeat with last_grant=1 -> order 2,3,0,1.
3. No interleave: port 1 sends a 3-beat packet with a 2-cycle gap before beat 3 while port 0 has a pending single beat -> beats 1,1,bubble,bubble,1(last), then port 0.
4. Backpressure: out_ready=0 for 5 cycles with port 3 streaming -> out_data is stable, FIFO 3 fills, and in_ready[3]=0 after 4 more beats (FIFO_DEPTH=4, plus 1 in the output register). Releasing out_ready drains all beats in order with no loss or duplication.
5. Full boundary: push to a full FIFO with in_valid=1 -> no write; a simultaneous pop and push on a FIFO with count 3 keeps count 3.
6. Reset mid-packet: assert reset during beat 2 of a 4-beat packet -> out_valid=0 immediately, in_ready=0 while reset is asserted and 1 after release; the next packet from port 3 appears with out_src=3 and no stale beats.
